// File: rtl/pipe_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
// Scoreboard entries hold destination registers up to RD_MAX_W bits.
package pipe_pkg;

  // Widest supported register address; REG_AW must not exceed this.
  localparam int RD_MAX_W = 8;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wen;
    logic                is_load;
  } sb_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority match of one source operand against the scoreboard.
// The youngest matching stage wins; x0 never matches.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = sel_w(FWD_DEPTH)
) (
  input  sb_entry_t           sb [FWD_DEPTH],
  input  logic [RD_MAX_W-1:0] src,
  input  logic                use_src,
  output logic [SEL_W-1:0]    sel,
  output logic                load_hit
);

  logic found;
  logic found_load;

  // Scan from the youngest stage; first hit sets the select.
  always_comb begin
    sel        = SEL_W'(FWD_RF);
    found      = 1'b0;
    found_load = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!found && sb[k].valid && sb[k].wen &&
          sb[k].rd == src && src != '0) begin
        found      = 1'b1;
        sel        = SEL_W'(k + 1);
        found_load = sb[k].is_load;
      end
    end
    if (!use_src) begin
      sel        = SEL_W'(FWD_RF);
      found_load = 1'b0;
    end
    load_hit = found_load && (sel == SEL_W'(1));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: forwarding selects, load-use
// stalls, branch flushes, memory freezes and event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int REG_AW    = 5,
  parameter  int FWD_DEPTH = 2,
  parameter  int CNT_W     = 16,
  localparam int SEL_W     = sel_w(FWD_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_ready,
  output logic [SEL_W-1:0]  fwd_sel_rs1,
  output logic [SEL_W-1:0]  fwd_sel_rs2,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              issue,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t sb [FWD_DEPTH];
  sb_entry_t new_entry;

  logic [RD_MAX_W-1:0] rs1_x;
  logic [RD_MAX_W-1:0] rs2_x;
  logic [RD_MAX_W-1:0] rd_x;
  logic                hit1_load;
  logic                hit2_load;
  logic                load_use;

  assign rs1_x = RD_MAX_W'(id_rs1);
  assign rs2_x = RD_MAX_W'(id_rs2);
  assign rd_x  = RD_MAX_W'(id_rd);

  pipe_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W)
  ) u_match_rs1 (
    .sb       (sb),
    .src      (rs1_x),
    .use_src  (id_use_rs1),
    .sel      (fwd_sel_rs1),
    .load_hit (hit1_load)
  );

  pipe_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W)
  ) u_match_rs2 (
    .sb       (sb),
    .src      (rs2_x),
    .use_src  (id_use_rs2),
    .sel      (fwd_sel_rs2),
    .load_hit (hit2_load)
  );

  assign load_use = id_valid && (hit1_load || hit2_load);

  // Pick freeze, flush, load-use stall or issue, in that priority.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    issue    = 1'b0;
    if (!mem_ready) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  // Entry entering stage 1: the issued instruction or a bubble.
  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = rd_x;
      new_entry.wen     = id_wen;
      new_entry.is_load = id_is_load;
    end
  end

  // Shift the scoreboard unless memory freezes the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
    end else if (mem_ready) begin
      sb[0] <= new_entry;
      for (int k = 1; k < FWD_DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  // Saturating count of decode stall cycles.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (stall_id && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // Saturating count of decode flush cycles.
  always_ff @(posedge clk) begin
    if (reset) flush_cnt <= '0;
    else if (flush_id && flush_cnt != CNT_MAX)
      flush_cnt <= flush_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, corner
// sequences, and random traffic against a queue-based model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int D  = 3;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          id_wen, id_is_load;
  logic          ex_branch_taken, mem_ready;
  logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic          stall_if, stall_id, flush_id, issue;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW    (AW),
    .FWD_DEPTH (D),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_wen          (id_wen),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_ready       (mem_ready),
    .fwd_sel_rs1     (fwd_sel_rs1),
    .fwd_sel_rs2     (fwd_sel_rs2),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush_id        (flush_id),
    .issue           (issue),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  typedef struct {
    logic          rst;
    logic          v;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic [AW-1:0] rd;
    logic          wen;
    logic          ld;
    logic          br;
    logic          mr;
  } in_t;

  typedef struct {
    in_t         i;
    logic [15:0] e;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit w;
    bit ld;
  } ent_t;

  int errors = 0;
  int checks = 0;

  ent_t pipe [$];
  int   msc;
  int   mfc;

  function automatic in_t mk(logic v, int rs1, logic u1,
                             int rs2, logic u2, int rd,
                             logic wen, logic ld,
                             logic br, logic mr);
    in_t x;
    x.rst = 1'b0;
    x.v   = v;
    x.rs1 = AW'(rs1);
    x.u1  = u1;
    x.rs2 = AW'(rs2);
    x.u2  = u2;
    x.rd  = AW'(rd);
    x.wen = wen;
    x.ld  = ld;
    x.br  = br;
    x.mr  = mr;
    return x;
  endfunction

  function automatic in_t mk_rst();
    in_t x;
    x     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    x.rst = 1'b1;
    return x;
  endfunction

  // Packed outputs: s1,s2,stall_if,stall_id,flush,issue,scnt,fcnt
  function automatic logic [15:0] ex(int s1, int s2, bit sif,
                                     bit sid, bit fl, bit iss,
                                     int sc, int fc);
    return {2'(s1), 2'(s2), sif, sid, fl, iss, 4'(sc), 4'(fc)};
  endfunction

  function automatic logic [15:0] act();
    return {fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_id,
            flush_id, issue, stall_cnt, flush_cnt};
  endfunction

  task automatic check(string name, logic [15:0] got,
                       logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, got, want, $time);
    end
  endtask

  task automatic check1(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic apply(in_t x);
    @(negedge clk);
    reset           = x.rst;
    id_valid        = x.v;
    id_rs1          = x.rs1;
    id_use_rs1      = x.u1;
    id_rs2          = x.rs2;
    id_use_rs2      = x.u2;
    id_rd           = x.rd;
    id_wen          = x.wen;
    id_is_load      = x.ld;
    ex_branch_taken = x.br;
    mem_ready       = x.mr;
    #1;
  endtask

  task automatic model_reset();
    ent_t b;
    b = '{0, 0, 0, 0};
    pipe.delete();
    repeat (D) pipe.push_back(b);
    msc = 0;
    mfc = 0;
  endtask

  // Youngest in-flight writer of r, counted from 1; 0 if none.
  function automatic int mfind(int r, bit u);
    if (!u || r == 0) return 0;
    for (int k = 0; k < pipe.size(); k++)
      if (pipe[k].v && pipe[k].w && pipe[k].rd == r) return k + 1;
    return 0;
  endfunction

  function automatic logic [15:0] model_out(in_t x);
    int s1, s2;
    bit lu, sif, fl, iss;
    s1  = mfind(int'(x.rs1), x.u1);
    s2  = mfind(int'(x.rs2), x.u2);
    lu  = x.v && (s1 == 1 || s2 == 1) && pipe[0].ld;
    sif = 0;
    fl  = 0;
    iss = 0;
    if (!x.mr)     sif = 1;
    else if (x.br) fl  = 1;
    else if (lu)   sif = 1;
    else           iss = x.v;
    return ex(s1, s2, sif, sif, fl, iss, msc, mfc);
  endfunction

  task automatic model_commit(in_t x);
    logic [15:0] e;
    ent_t n;
    e = model_out(x);
    if (x.rst) begin
      model_reset();
    end else begin
      if (e[10] && msc < CMAX) msc++;
      if (e[9] && mfc < CMAX) mfc++;
      if (x.mr) begin
        n = '{0, 0, 0, 0};
        if (e[8]) n = '{1, int'(x.rd), x.wen, x.ld};
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
    end
  endtask

  task automatic do_reset();
    apply(mk_rst());
    apply(mk_rst());
    model_reset();
  endtask

  vec_t tbl [$];

  initial begin
    in_t x;
    logic [15:0] e;

    do_reset();

    // Directed sequence from an empty scoreboard.
    tbl.push_back('{mk(0,0,0,0,0,0,0,0,0,1), ex(0,0,0,0,0,0,0,0)});
    tbl.push_back('{mk(1,0,0,0,0,5,1,0,0,1), ex(0,0,0,0,0,1,0,0)});
    tbl.push_back('{mk(1,5,1,0,1,6,1,0,0,1), ex(1,0,0,0,0,1,0,0)});
    tbl.push_back('{mk(1,6,1,0,0,7,1,1,0,1), ex(1,0,0,0,0,1,0,0)});
    tbl.push_back('{mk(1,7,1,5,1,8,1,0,0,1), ex(1,3,1,1,0,0,0,0)});
    tbl.push_back('{mk(1,7,1,5,1,8,1,0,0,1), ex(2,0,0,0,0,1,1,0)});
    tbl.push_back('{mk(1,8,1,0,0,0,1,0,0,1), ex(1,0,0,0,0,1,1,0)});
    tbl.push_back('{mk(1,0,1,0,1,9,0,0,0,1), ex(0,0,0,0,0,1,1,0)});
    tbl.push_back('{mk(1,9,1,8,1,10,1,1,0,1), ex(0,3,0,0,0,1,1,0)});
    tbl.push_back('{mk(1,10,1,0,0,11,1,0,1,1), ex(1,0,0,0,1,0,1,0)});
    tbl.push_back('{mk(1,10,1,0,0,11,1,0,1,0), ex(2,0,1,1,0,0,1,1)});
    tbl.push_back('{mk(1,10,1,0,0,11,1,0,1,0), ex(2,0,1,1,0,0,2,1)});
    tbl.push_back('{mk(1,10,1,0,0,11,1,0,1,0), ex(2,0,1,1,0,0,3,1)});
    tbl.push_back('{mk(1,10,1,0,0,11,1,0,1,1), ex(2,0,0,0,1,0,4,1)});
    tbl.push_back('{mk(1,10,1,10,0,12,1,0,0,1), ex(3,0,0,0,0,1,4,2)});
    tbl.push_back('{mk(0,12,1,0,0,0,0,0,0,1), ex(1,0,0,0,0,0,4,2)});
    tbl.push_back('{mk(1,0,0,0,0,13,1,1,0,1), ex(0,0,0,0,0,1,4,2)});
    tbl.push_back('{mk(0,13,1,0,0,0,0,0,0,1), ex(1,0,0,0,0,0,4,2)});

    for (int n = 0; n < tbl.size(); n++) begin
      apply(tbl[n].i);
      check($sformatf("vec%0d", n), act(), tbl[n].e);
      model_commit(tbl[n].i);
    end

    // Counter saturation over a long freeze, then reset.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      apply(mk(0,0,0,0,0,0,0,0,0,0));
      model_commit(mk(0,0,0,0,0,0,0,0,0,0));
    end
    apply(mk(0,0,0,0,0,0,0,0,0,1));
    check1("stall_sat", int'(stall_cnt), CMAX);
    apply(mk_rst());
    apply(mk(0,0,0,0,0,0,0,0,0,1));
    check1("stall_rst", int'(stall_cnt), 0);
    check1("flush_rst", int'(flush_cnt), 0);

    // Reset in the middle of a freeze drops in-flight writers.
    do_reset();
    apply(mk(1,0,0,0,0,5,1,0,0,1));
    apply(mk(1,5,1,0,0,6,1,0,0,0));
    check1("pre_rst_fwd", int'(fwd_sel_rs1), 1);
    x     = mk(1,5,1,0,0,6,1,0,0,0);
    x.rst = 1'b1;
    apply(x);
    apply(mk(1,5,1,5,1,6,1,0,0,1));
    check1("post_rst_fwd1", int'(fwd_sel_rs1), 0);
    check1("post_rst_fwd2", int'(fwd_sel_rs2), 0);
    check1("post_rst_issue", int'(issue), 1);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      x.rst = ($urandom_range(0, 59) == 0);
      x.v   = $urandom_range(0, 3) != 0;
      x.rs1 = AW'($urandom_range(0, 7));
      x.u1  = $urandom_range(0, 3) != 0;
      x.rs2 = AW'($urandom_range(0, 7));
      x.u2  = $urandom_range(0, 1);
      x.rd  = AW'($urandom_range(0, 7));
      x.wen = $urandom_range(0, 4) != 0;
      x.ld  = $urandom_range(0, 2) == 0;
      x.br  = $urandom_range(0, 7) == 0;
      x.mr  = $urandom_range(0, 5) != 0;
      apply(x);
      e = model_out(x);
      check("rand", act(), e);
      model_commit(x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
